// File: rtl/hw_accel_dma_pkg.sv
// Shared definitions for the DMA responder: FSM encoding, checksum width
// and the checksum accumulate helper.
package hw_accel_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int CSUM_W = 32;

   // Checksum is a plain modulo-2^32 sum of the received words
   function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                  input logic [CSUM_W-1:0] word);
      return acc + word;
   endfunction

endpackage

// File: rtl/hw_accel_skid_buf.sv
// Two-entry skid buffer with registered in_ready, out_valid and out_data.
// accept_nxt lets the parent close the input for the next cycle while the
// ready output stays a pure register.
module hw_accel_skid_buf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  accept_nxt,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  skid_vld;
   logic                  skid_vld_nxt;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  in_fire;
   logic                  out_free;

   assign in_fire  = in_valid & in_ready;
   assign out_free = out_ready | ~out_valid;

   // Skid slot fills only when a word arrives while the output is stalled
   always_comb begin
      skid_vld_nxt = skid_vld;
      if (out_free) begin
         skid_vld_nxt = 1'b0;
      end else if (in_fire) begin
         skid_vld_nxt = 1'b1;
      end
   end

   // Output register refills from the skid slot first, then from the input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
         in_ready  <= 1'b0;
      end else begin
         if (out_free) begin
            if (skid_vld) begin
               out_valid <= 1'b1;
               out_data  <= skid_data;
            end else begin
               out_valid <= in_fire;
               if (in_fire) begin
                  out_data <= in_data;
               end
            end
         end else if (in_fire) begin
            skid_data <= in_data;
         end
         skid_vld <= skid_vld_nxt;
         in_ready <= accept_nxt & ~skid_vld_nxt;
      end
   end

endmodule

// File: rtl/hw_accel_dma_responder.sv
// DMA responder: streams one frame of source words out over MM2S while
// receiving, counting and checksumming one frame of S2MM words, and checks
// the S2MM wlast framing.
module hw_accel_dma_responder
   import hw_accel_dma_pkg::*;
#(
   parameter int DATA_WIDTH          = 32,
   parameter int IN_FRAME_WORDS      = 307200,
   parameter int OUT_TRANSFER_LENGTH = 1920,
   parameter int OUT_FRAME_WORDS     = 9216
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic                    src_valid,
   output logic                    src_ready,
   input  logic [DATA_WIDTH-1:0]   src_data,
   output logic                    dma_rvalid,
   input  logic                    dma_rready,
   output logic [DATA_WIDTH/8-1:0] dma_rkeep,
   output logic [DATA_WIDTH-1:0]   dma_rdata,
   input  logic                    dma_wvalid,
   output logic                    dma_wready,
   input  logic                    dma_wlast,
   input  logic [DATA_WIDTH-1:0]   dma_wdata,
   output logic [31:0]             rx_word_count,
   output logic [CSUM_W-1:0]       rx_checksum,
   output logic                    err_wlast_early,
   output logic                    err_wlast_missing,
   output logic                    err_unexpected_w
);

   localparam int TXC_W = $clog2(IN_FRAME_WORDS + 1);
   localparam int RXC_W = $clog2(OUT_FRAME_WORDS + 1);
   localparam int XFC_W = $clog2(OUT_TRANSFER_LENGTH + 1);
   localparam logic [TXC_W-1:0] TX_N = TXC_W'(IN_FRAME_WORDS);
   localparam logic [RXC_W-1:0] RX_N = RXC_W'(OUT_FRAME_WORDS);
   localparam logic [XFC_W-1:0] XF_N = XFC_W'(OUT_TRANSFER_LENGTH);

   state_t           state;
   state_t           state_nxt;
   logic             start_acc;
   logic             src_fire;
   logic             rd_fire;
   logic             w_fire;
   logic [TXC_W-1:0] tx_acc_cnt;
   logic [TXC_W-1:0] tx_acc_nxt;
   logic [TXC_W-1:0] tx_out_cnt;
   logic [RXC_W-1:0] rx_cnt;
   logic [XFC_W-1:0] xfer_idx;
   logic             accept_nxt;
   logic             tx_done_now;
   logic             rx_last_word;
   logic             rx_done_now;
   logic             wlast_exp;

   assign start_acc    = start & (state == ST_IDLE);
   assign src_fire     = src_valid & src_ready;
   assign rd_fire      = dma_rvalid & dma_rready;
   assign w_fire       = dma_wvalid & dma_wready;
   assign rx_last_word = (rx_cnt == RX_N - 1'b1);
   // "done now" includes a completing handshake in this very cycle
   assign tx_done_now  = (tx_out_cnt == TX_N) | (rd_fire & (tx_out_cnt == TX_N - 1'b1));
   assign rx_done_now  = (rx_cnt == RX_N) | (w_fire & rx_last_word);
   assign wlast_exp    = (xfer_idx == XF_N - 1'b1) | rx_last_word;
   assign accept_nxt   = (state_nxt == ST_RUN) & (tx_acc_nxt < TX_N);
   assign dma_rkeep    = {(DATA_WIDTH/8){dma_rvalid}};
   assign rx_word_count = 32'(rx_cnt);

   hw_accel_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept_nxt (accept_nxt),
      .in_valid   (src_valid),
      .in_ready   (src_ready),
      .in_data    (src_data),
      .out_valid  (dma_rvalid),
      .out_ready  (dma_rready),
      .out_data   (dma_rdata)
   );

   // Source words accepted this frame, cleared by an accepted start
   always_comb begin
      tx_acc_nxt = tx_acc_cnt;
      if (start_acc) begin
         tx_acc_nxt = '0;
      end else if (src_fire) begin
         tx_acc_nxt = tx_acc_cnt + 1'b1;
      end
   end

   // Frame FSM next state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (tx_done_now && rx_done_now) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Frame FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // TX/RX counters, S2MM result registers and framing error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_acc_cnt        <= '0;
         tx_out_cnt        <= '0;
         rx_cnt            <= '0;
         xfer_idx          <= '0;
         rx_checksum       <= '0;
         err_wlast_early   <= 1'b0;
         err_wlast_missing <= 1'b0;
         err_unexpected_w  <= 1'b0;
         dma_wready        <= 1'b0;
      end else begin
         tx_acc_cnt <= tx_acc_nxt;
         if (start_acc) begin
            tx_out_cnt        <= '0;
            rx_cnt            <= '0;
            xfer_idx          <= '0;
            rx_checksum       <= '0;
            err_wlast_early   <= 1'b0;
            err_wlast_missing <= 1'b0;
            dma_wready        <= 1'b1;
         end else begin
            if (rd_fire) begin
               tx_out_cnt <= tx_out_cnt + 1'b1;
            end
            if (w_fire) begin
               rx_cnt      <= rx_cnt + 1'b1;
               rx_checksum <= csum_add(rx_checksum, CSUM_W'(dma_wdata));
               xfer_idx    <= wlast_exp ? '0 : xfer_idx + 1'b1;
               if (dma_wlast && !wlast_exp) begin
                  err_wlast_early <= 1'b1;
               end
               if (!dma_wlast && wlast_exp) begin
                  err_wlast_missing <= 1'b1;
               end
               if (rx_last_word) begin
                  dma_wready <= 1'b0;
               end
            end
         end
         // A write offered while idle is flagged and never accepted
         if ((state == ST_IDLE) && dma_wvalid) begin
            err_unexpected_w <= 1'b1;
         end else if (start_acc) begin
            err_unexpected_w <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hw_accel_dma_responder.sv
// Randomized bench for hw_accel_dma_responder with a queue/counter based
// frame model: accepted source words must come out on MM2S in order, S2MM
// words are counted and summed, and wlast is expected on every
// OUT_TRANSFER_LENGTH-th word and on the last frame word.
module tb_hw_accel_dma_responder;

   localparam int DW    = 32;
   localparam int IN_W  = 8;
   localparam int OTL   = 4;
   localparam int OUT_W = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic          src_valid;
   logic          src_ready;
   logic [DW-1:0] src_data;
   logic          dma_rvalid;
   logic          dma_rready;
   logic [3:0]    dma_rkeep;
   logic [DW-1:0] dma_rdata;
   logic          dma_wvalid;
   logic          dma_wready;
   logic          dma_wlast;
   logic [DW-1:0] dma_wdata;
   logic [31:0]   rx_word_count;
   logic [31:0]   rx_checksum;
   logic          err_wlast_early;
   logic          err_wlast_missing;
   logic          err_unexpected_w;

   hw_accel_dma_responder #(
      .DATA_WIDTH          (DW),
      .IN_FRAME_WORDS      (IN_W),
      .OUT_TRANSFER_LENGTH (OTL),
      .OUT_FRAME_WORDS     (OUT_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .src_valid         (src_valid),
      .src_ready         (src_ready),
      .src_data          (src_data),
      .dma_rvalid        (dma_rvalid),
      .dma_rready        (dma_rready),
      .dma_rkeep         (dma_rkeep),
      .dma_rdata         (dma_rdata),
      .dma_wvalid        (dma_wvalid),
      .dma_wready        (dma_wready),
      .dma_wlast         (dma_wlast),
      .dma_wdata         (dma_wdata),
      .rx_word_count     (rx_word_count),
      .rx_checksum       (rx_checksum),
      .err_wlast_early   (err_wlast_early),
      .err_wlast_missing (err_wlast_missing),
      .err_unexpected_w  (err_unexpected_w)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // model state
   logic [31:0] exp_q[$];
   int          accepted, delivered, rx_n;
   logic [31:0] rx_sum;
   bit          m_early, m_missing, m_unexp;
   bit          busy_exp, done_exp;
   bit          prev_stall;
   logic [31:0] prev_data;
   bit          tog;

   // stimulus configuration
   int cfg_src, cfg_rready, cfg_w;
   bit cfg_seq, cfg_sync, cfg_idle_w;
   int cfg_early, cfg_drop, cfg_restart_at;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit exp_last(input int idx);
      return ((idx % OTL) == 0) || (idx == OUT_W);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      accepted = 0; delivered = 0; rx_n = 0; rx_sum = '0;
      m_early = 0; m_missing = 0; m_unexp = 0;
      busy_exp = 0; done_exp = 0; prev_stall = 0; prev_data = '0; tog = 1;
   endtask

   task automatic set_cfg(input int s, input int r, input int w, input bit seq,
                          input bit sync, input int early, input int drop, input int restart);
      cfg_src = s; cfg_rready = r; cfg_w = w; cfg_seq = seq; cfg_sync = sync;
      cfg_early = early; cfg_drop = drop; cfg_restart_at = restart; cfg_idle_w = 0;
   endtask

   // Called at a falling edge: check outputs, drive inputs, advance the model
   task automatic step(input bit start_v);
      bit idle_m, in_fire, r_fire, w_fire, el;
      int idx;
      idle_m = !busy_exp && !done_exp;
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("done", 32'(done), 32'(done_exp));
      chk("rvalid", 32'(dma_rvalid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("rdata", dma_rdata, exp_q[0]);
      chk("rkeep", 32'(dma_rkeep), (exp_q.size() > 0) ? 32'hF : 32'h0);
      if (prev_stall) chk("stall_hold", dma_rdata, prev_data);
      chk("wready", 32'(dma_wready), 32'(busy_exp && (rx_n < OUT_W)));
      if (accepted == IN_W || !busy_exp) chk("src_ready_off", 32'(src_ready), 32'h0);
      else if (cfg_rready == 100) chk("src_ready_on", 32'(src_ready), 32'h1);
      chk("rx_count", rx_word_count, 32'(rx_n));
      chk("rx_csum", rx_checksum, rx_sum);
      chk("err_early", 32'(err_wlast_early), 32'(m_early));
      chk("err_missing", 32'(err_wlast_missing), 32'(m_missing));
      chk("err_unexp", 32'(err_unexpected_w), 32'(m_unexp));

      start     = start_v;
      src_valid = ($urandom_range(99) < cfg_src);
      src_data  = cfg_seq ? 32'(accepted + 1) : $urandom();
      if (cfg_rready < 0) begin
         dma_rready = tog;
         tog = !tog;
      end else begin
         dma_rready = ($urandom_range(99) < cfg_rready);
      end
      idx = rx_n + 1;
      dma_wvalid = busy_exp ? ($urandom_range(99) < cfg_w) : (cfg_idle_w && idle_m);
      el = exp_last(idx);
      dma_wlast = el;
      if (idx == cfg_early) dma_wlast = 1'b1;
      if (idx == cfg_drop)  dma_wlast = 1'b0;
      dma_wdata = cfg_seq ? 32'(idx) : $urandom();
      if (cfg_sync && busy_exp && (delivered == IN_W - 1 || rx_n == OUT_W - 1)) begin
         if (delivered == IN_W - 1 && rx_n == OUT_W - 1 && dma_rvalid && dma_wready) begin
            dma_rready = 1'b1;
            dma_wvalid = 1'b1;
         end else begin
            if (delivered == IN_W - 1) dma_rready = 1'b0;
            if (rx_n == OUT_W - 1)     dma_wvalid = 1'b0;
         end
      end

      in_fire = src_valid && src_ready;
      r_fire  = dma_rvalid && dma_rready;
      w_fire  = dma_wvalid && dma_wready;
      prev_stall = dma_rvalid && !dma_rready;
      prev_data  = dma_rdata;
      if (r_fire && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         delivered++;
      end
      if (in_fire) begin
         exp_q.push_back(src_data);
         accepted++;
      end
      if (w_fire) begin
         if (dma_wlast && !el) m_early = 1;
         if (!dma_wlast && el) m_missing = 1;
         rx_n++;
         rx_sum = rx_sum + dma_wdata;
      end
      if (done_exp) begin
         done_exp = 0;
      end else if (busy_exp) begin
         if (delivered == IN_W && rx_n == OUT_W) begin
            busy_exp = 0;
            done_exp = 1;
         end
      end else if (start_v) begin
         busy_exp = 1;
         accepted = 0; delivered = 0; rx_n = 0; rx_sum = '0;
         m_early = 0; m_missing = 0; m_unexp = 0;
      end
      if (idle_m && dma_wvalid) m_unexp = 1;

      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_frame();
      int n;
      step(1'b1);
      n = 1;
      while ((busy_exp || done_exp) && n < 400) begin
         step(n == cfg_restart_at);
         n++;
      end
      if (busy_exp || done_exp) chk("frame_timeout", 32'(n), 32'h0);
      step(1'b0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      start = 0; src_valid = 0; src_data = '0; dma_rready = 0;
      dma_wvalid = 0; dma_wlast = 0; dma_wdata = '0;
      #1;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_src_ready", 32'(src_ready), 32'h0);
      chk("rst_rvalid", 32'(dma_rvalid), 32'h0);
      chk("rst_rkeep", 32'(dma_rkeep), 32'h0);
      chk("rst_rdata", dma_rdata, 32'h0);
      chk("rst_wready", 32'(dma_wready), 32'h0);
      chk("rst_count", rx_word_count, 32'h0);
      chk("rst_csum", rx_checksum, 32'h0);
      chk("rst_errs", 32'({err_wlast_early, err_wlast_missing, err_unexpected_w}), 32'h0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_done", 32'(done), 32'h0);
      end
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      set_cfg(100, 100, 100, 1, 0, 0, 0, -1);
      @(negedge clk);
      apply_reset();
      step(1'b0);

      // sequential data, full throughput: rdata 1..8, wdata 1..10 sum 55
      set_cfg(100, 100, 100, 1, 0, 0, 0, -1);
      run_frame();
      // alternating rready stalls
      set_cfg(100, -1, 100, 1, 0, 0, 0, -1);
      run_frame();
      // wlast early on word 3, missing on word 4
      set_cfg(70, 70, 70, 0, 0, 3, 4, -1);
      run_frame();
      // clean frame clears the flags; start while busy is ignored
      set_cfg(80, 60, 80, 0, 0, 0, 0, 3);
      run_frame();
      // write offered while idle
      cfg_idle_w = 1;
      step(1'b0);
      cfg_idle_w = 0;
      step(1'b0);
      // final TX and RX handshakes in the same cycle
      set_cfg(100, 100, 100, 0, 1, 0, 0, -1);
      run_frame();
      // reset in the middle of a frame
      set_cfg(60, 60, 60, 0, 0, 0, 0, -1);
      step(1'b1);
      repeat (6) step(1'b0);
      apply_reset();
      step(1'b0);
      run_frame();
      // random frames with random framing faults
      for (int k = 0; k < 6; k++) begin
         set_cfg($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
                 0, 0, ($urandom_range(1) != 0) ? $urandom_range(OUT_W, 1) : 0,
                 ($urandom_range(1) != 0) ? $urandom_range(OUT_W, 1) : 0, -1);
         run_frame();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
